// File: rtl/fracnet_mul_share_arb_pkg.sv
// Shared constants, helper function and stage payload type for the
// shared 8x10 multiplier arbiter.
package fracnet_mul_pkg;

  localparam int unsigned A_W      = 8;
  localparam int unsigned B_W      = 10;
  localparam int unsigned P_W      = 18;
  // Tag width large enough for the largest supported requester count (8).
  localparam int unsigned ID_MAX_W = 3;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
    logic [A_W-1:0]      a;
    logic [B_W-1:0]      b;
  } stage_t;

endpackage

// File: rtl/fracnet_mul_share_arb_if.sv
// Requester/result bundle between the HLS loop bodies and the shared
// multiplier arbiter.
interface fracnet_mul_share_arb_if #(
  parameter int unsigned N_REQ = 4
);
  localparam int unsigned ID_W = fracnet_mul_pkg::clog2(N_REQ);

  logic                               ap_ce;
  logic [N_REQ-1:0]                   req_valid;
  logic [N_REQ*fracnet_mul_pkg::A_W-1:0] req_a;
  logic [N_REQ*fracnet_mul_pkg::B_W-1:0] req_b;
  logic [N_REQ-1:0]                   req_ready;
  logic [N_REQ-1:0]                   res_valid;
  logic [ID_W-1:0]                    res_id;
  logic [fracnet_mul_pkg::P_W-1:0]    res_p;
  logic [2:0]                         inflight;

  modport master (
    output ap_ce, req_valid, req_a, req_b,
    input  req_ready, res_valid, res_id, res_p, inflight
  );

  modport slave (
    input  ap_ce, req_valid, req_a, req_b,
    output req_ready, res_valid, res_id, res_p, inflight
  );

endinterface

// File: rtl/fracnet_mul_share_arb_pipe.sv
// Pipelined unsigned 8x10 multiplier with clock enable, STAGES registers
// from operand input to product output (DSP48 A/B, M and P registers).
module fracnet_mul_pipe
  import fracnet_mul_pkg::*;
#(
  parameter int unsigned STAGES = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ce,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  output logic [P_W-1:0] p
);

  if (STAGES == 1) begin : g_one
    logic [P_W-1:0] p_q;

    // Single-stage: multiply straight into the output register.
    always_ff @(posedge clk) begin
      if (rst) begin
        p_q <= '0;
      end else if (ce) begin
        p_q <= P_W'(a) * P_W'(b);
      end
    end

    assign p = p_q;
  end else begin : g_multi
    logic [A_W-1:0] a_q;
    logic [B_W-1:0] b_q;
    logic [P_W-1:0] m_q [STAGES-1];

    // Operand registers, then product register followed by delay stages.
    always_ff @(posedge clk) begin
      if (rst) begin
        a_q <= '0;
        b_q <= '0;
        for (int unsigned k = 0; k < STAGES - 1; k++) m_q[k] <= '0;
      end else if (ce) begin
        a_q    <= a;
        b_q    <= b;
        m_q[0] <= P_W'(a_q) * P_W'(b_q);
        for (int unsigned k = 1; k < STAGES - 1; k++) m_q[k] <= m_q[k-1];
      end
    end

    assign p = m_q[STAGES-2];
  end

endmodule

// File: rtl/fracnet_mul_share_arb.sv
// Round-robin arbiter that time-shares one pipelined 8x10 multiplier
// among N_REQ requesters and returns tagged products after MUL_STAGES cycles.
module fracnet_mul_share_arb
  import fracnet_mul_pkg::*;
#(
  parameter int unsigned N_REQ      = 4,
  parameter int unsigned MUL_STAGES = 2
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  fracnet_mul_share_arb_if.slave  bus
);

  localparam int unsigned ID_W = clog2(N_REQ);
  localparam int unsigned LAST = MUL_STAGES - 1;

  logic [A_W-1:0]      a_arr [N_REQ];
  logic [B_W-1:0]      b_arr [N_REQ];
  logic [N_REQ-1:0]    grant;
  logic                found;
  logic [ID_W-1:0]     ptr;
  logic [ID_W-1:0]     idx;
  logic [ID_W-1:0]     gidx;
  stage_t              issue;
  logic                tag_vld [MUL_STAGES];
  logic [ID_MAX_W-1:0] tag_id  [MUL_STAGES];
  logic                retire;
  logic [P_W-1:0]      prod;
  logic [ID_W-1:0]     res_id_q;
  logic [P_W-1:0]      res_p_q;
  logic [2:0]          cnt;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign a_arr[i] = bus.req_a[i*A_W +: A_W];
    assign b_arr[i] = bus.req_b[i*B_W +: B_W];
  end

  // Round-robin search from ptr, wrapping modulo N_REQ; first valid wins.
  always_comb begin
    grant = '0;
    found = 1'b0;
    gidx  = '0;
    issue = '0;
    idx   = ptr;
    if (bus.ap_ce) begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        if (!found && bus.req_valid[idx]) begin
          found       = 1'b1;
          gidx        = idx;
          grant[idx]  = 1'b1;
          issue.valid = 1'b1;
          issue.id    = ID_MAX_W'(idx);
          issue.a     = a_arr[idx];
          issue.b     = b_arr[idx];
        end
        idx = (idx == ID_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
      end
    end
  end

  assign retire = tag_vld[LAST] & bus.ap_ce;

  // Pointer, tag shift register, inflight count and result hold registers.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      ptr      <= '0;
      cnt      <= '0;
      res_id_q <= '0;
      res_p_q  <= '0;
      for (int unsigned k = 0; k < MUL_STAGES; k++) begin
        tag_vld[k] <= 1'b0;
        tag_id[k]  <= '0;
      end
    end else if (bus.ap_ce) begin
      if (found) ptr <= (gidx == ID_W'(N_REQ - 1)) ? '0 : gidx + 1'b1;
      tag_vld[0] <= issue.valid;
      tag_id[0]  <= issue.id;
      for (int unsigned k = 1; k < MUL_STAGES; k++) begin
        tag_vld[k] <= tag_vld[k-1];
        tag_id[k]  <= tag_id[k-1];
      end
      unique case ({found, retire})
        2'b10:   cnt <= cnt + 3'd1;
        2'b01:   cnt <= cnt - 3'd1;
        default: cnt <= cnt;
      endcase
      if (retire) begin
        res_id_q <= tag_id[LAST][ID_W-1:0];
        res_p_q  <= prod;
      end
    end
  end

  fracnet_mul_pipe #(
    .STAGES (MUL_STAGES)
  ) u_pipe (
    .clk (ap_clk),
    .rst (ap_rst),
    .ce  (bus.ap_ce),
    .a   (issue.a),
    .b   (issue.b),
    .p   (prod)
  );

  for (genvar i = 0; i < N_REQ; i++) begin : g_res
    assign bus.res_valid[i] = retire && (tag_id[LAST] == ID_MAX_W'(i));
  end

  // Outside a retiring cycle the last delivered id/product stay visible.
  assign bus.req_ready = grant;
  assign bus.res_id    = retire ? tag_id[LAST][ID_W-1:0] : res_id_q;
  assign bus.res_p     = retire ? prod : res_p_q;
  assign bus.inflight  = cnt;

endmodule

// File: tb/tb_fracnet_mul_share_arb.sv
// Directed bench for the shared-multiplier round-robin arbiter.
module tb_fracnet_mul_share_arb;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   exp_p [4];

  fracnet_mul_share_arb_if #(.N_REQ(4)) bus ();

  fracnet_mul_share_arb #(
    .N_REQ      (4),
    .MUL_STAGES (2)
  ) dut (
    .ap_clk (clk),
    .ap_rst (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [7:0] a, input logic [9:0] b);
    bus.req_a[i*8 +: 8]   = a;
    bus.req_b[i*10 +: 10] = b;
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.ap_ce     = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    exp_p         = '{1000, 1111, 1224, 1339};

    // Reset state
    next_cycle();
    next_cycle();
    #1;
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_id", bus.res_id, 0);
    chk("rst_res_p", bus.res_p, 0);
    chk("rst_inflight", bus.inflight, 0);

    // Reset mid-operation
    rst = 1'b0;
    set_op(1, 8'd3, 10'd5);
    bus.req_valid = 4'b0010;
    #1;
    chk("midrst_grant", bus.req_ready, 4'b0010);
    next_cycle();
    bus.req_valid = 4'b0000;
    rst = 1'b1;
    #1;
    chk("midrst_inflight_pre", bus.inflight, 1);
    next_cycle();
    #1;
    chk("midrst_res_valid_a", bus.res_valid, 0);
    chk("midrst_inflight_a", bus.inflight, 0);
    next_cycle();
    rst = 1'b0;
    #1;
    chk("midrst_res_valid_b", bus.res_valid, 0);
    chk("midrst_inflight_b", bus.inflight, 0);
    set_op(0, 8'd0, 10'd777);
    bus.req_valid = 4'b1111;
    #1;
    chk("midrst_ptr0", bus.req_ready, 4'b0001);
    next_cycle();
    bus.req_valid = 4'b0000;
    #1;
    chk("zero_inflight", bus.inflight, 1);
    chk("zero_res_valid_early", bus.res_valid, 0);
    next_cycle();
    #1;
    chk("zero_res_valid", bus.res_valid, 4'b0001);
    chk("zero_res_p", bus.res_p, 0);
    next_cycle();

    // Single transfer, max operands (ptr = 1)
    set_op(2, 8'd255, 10'd1023);
    bus.req_valid = 4'b0100;
    #1;
    chk("single_grant", bus.req_ready, 4'b0100);
    next_cycle();
    bus.req_valid = 4'b0000;
    #1;
    chk("single_inflight_1", bus.inflight, 1);
    chk("single_res_valid_early", bus.res_valid, 0);
    next_cycle();
    #1;
    chk("single_res_valid", bus.res_valid, 4'b0100);
    chk("single_res_id", bus.res_id, 2);
    chk("single_res_p", bus.res_p, 260865);
    next_cycle();
    #1;
    chk("single_inflight_0", bus.inflight, 0);
    chk("single_res_valid_off", bus.res_valid, 0);
    chk("single_hold_p", bus.res_p, 260865);
    chk("single_hold_id", bus.res_id, 2);

    // Skip and wrap (ptr = 3), only req 1 and req 3 valid
    set_op(1, 8'd6, 10'd7);
    set_op(3, 8'd10, 10'd100);
    bus.req_valid = 4'b1010;
    #1;
    chk("skip_g0", bus.req_ready, 4'b1000);
    next_cycle();
    #1;
    chk("skip_g1", bus.req_ready, 4'b0010);
    next_cycle();
    #1;
    chk("skip_g2", bus.req_ready, 4'b1000);
    chk("skip_r0_valid", bus.res_valid, 4'b1000);
    chk("skip_r0_p", bus.res_p, 1000);
    next_cycle();
    bus.req_valid = 4'b0000;
    #1;
    chk("skip_r1_valid", bus.res_valid, 4'b0010);
    chk("skip_r1_id", bus.res_id, 1);
    chk("skip_r1_p", bus.res_p, 42);
    chk("skip_inflight", bus.inflight, 2);
    next_cycle();
    #1;
    chk("skip_r2_valid", bus.res_valid, 4'b1000);
    chk("skip_r2_p", bus.res_p, 1000);
    next_cycle();

    // Fairness: all four valid for 8 cycles (ptr = 0)
    for (int i = 0; i < 4; i++) set_op(i, 8'(10 + i), 10'(100 + i));
    for (int k = 0; k < 8; k++) begin
      bus.req_valid = 4'b1111;
      #1;
      chk("fair_grant", bus.req_ready, 32'(1 << (k % 4)));
      if (k >= 2) begin
        chk("fair_res_valid", bus.res_valid, 32'(1 << ((k - 2) % 4)));
        chk("fair_res_p", bus.res_p, 32'(exp_p[(k - 2) % 4]));
      end
      next_cycle();
    end
    bus.req_valid = 4'b0000;
    #1;
    chk("fair_inflight", bus.inflight, 2);
    chk("fair_tail0_valid", bus.res_valid, 4'b0100);
    chk("fair_tail0_p", bus.res_p, 1224);
    next_cycle();
    #1;
    chk("fair_tail1_valid", bus.res_valid, 4'b1000);
    chk("fair_tail1_p", bus.res_p, 1339);
    next_cycle();

    // Stall: three grants then ap_ce low for 3 cycles (ptr = 0)
    set_op(0, 8'd2, 10'd3);
    set_op(1, 8'd4, 10'd5);
    set_op(2, 8'd100, 10'd1000);
    bus.req_valid = 4'b0001;
    #1;
    chk("stall_g0", bus.req_ready, 4'b0001);
    next_cycle();
    bus.req_valid = 4'b0010;
    #1;
    chk("stall_g1", bus.req_ready, 4'b0010);
    next_cycle();
    bus.req_valid = 4'b0100;
    #1;
    chk("stall_g2", bus.req_ready, 4'b0100);
    chk("stall_r0_valid", bus.res_valid, 4'b0001);
    chk("stall_r0_p", bus.res_p, 6);
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      bus.ap_ce     = 1'b0;
      bus.req_valid = 4'b0111;
      #1;
      chk("stall_ready", bus.req_ready, 0);
      chk("stall_res_valid", bus.res_valid, 0);
      chk("stall_inflight", bus.inflight, 2);
      chk("stall_hold_p", bus.res_p, 6);
      next_cycle();
    end
    bus.ap_ce     = 1'b1;
    bus.req_valid = 4'b0000;
    #1;
    chk("stall_r1_valid", bus.res_valid, 4'b0010);
    chk("stall_r1_id", bus.res_id, 1);
    chk("stall_r1_p", bus.res_p, 20);
    chk("stall_r1_inflight", bus.inflight, 2);
    next_cycle();
    #1;
    chk("stall_r2_valid", bus.res_valid, 4'b0100);
    chk("stall_r2_p", bus.res_p, 100000);
    chk("stall_r2_inflight", bus.inflight, 1);
    next_cycle();
    #1;
    chk("stall_done_valid", bus.res_valid, 0);
    chk("stall_done_inflight", bus.inflight, 0);

    // Operand stability (ptr = 3): a changes after the grant edge
    set_op(0, 8'd7, 10'd4);
    bus.req_valid = 4'b0001;
    #1;
    chk("stab_grant", bus.req_ready, 4'b0001);
    next_cycle();
    bus.req_valid = 4'b0000;
    set_op(0, 8'd9, 10'd4);
    next_cycle();
    #1;
    chk("stab_res_valid", bus.res_valid, 4'b0001);
    chk("stab_res_p", bus.res_p, 28);
    next_cycle();

    // Single requester granted every cycle (ptr = 1)
    set_op(2, 8'd3, 10'd3);
    for (int k = 0; k < 4; k++) begin
      bus.req_valid = 4'b0100;
      #1;
      chk("solo_grant", bus.req_ready, 4'b0100);
      if (k >= 2) chk("solo_res_valid", bus.res_valid, 4'b0100);
      next_cycle();
    end
    bus.req_valid = 4'b0000;
    next_cycle();
    next_cycle();
    #1;
    chk("solo_drain_inflight", bus.inflight, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
